// File: rtl/pir_pkg.sv
// Shared types and default timing constants for the PIR motion conditioner.
package pir_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        HOLD   = 2'd3
    } pir_state_t;

    localparam int PIR_WARMUP_CYCLES   = 1_480_000;
    localparam int PIR_DEBOUNCE_CYCLES = 148_000;
    localparam int PIR_HOLD_CYCLES     = 300_000_000;
    localparam int EVENT_COUNT_W       = 16;

    // Counter width for a terminal count of n-1; a 1-cycle count still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pir_debounce.sv
// Two-flop synchroniser followed by a persistence debouncer: a new level is
// accepted only after it has disagreed with the output for DEBOUNCE_CYCLES edges.
module pir_debounce
    import pir_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PIR_DEBOUNCE_CYCLES
) (
    input  logic clk_148_mhz,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_148_mhz) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/pir_motion_conditioner.sv
// PIR sensor conditioner: warm-up blanking, debounce, retriggerable hold and
// episode-start pulse. Define PIR_EVENT_COUNT_EN to add the saturating event_count port.
module pir_motion_conditioner
    import pir_pkg::*;
#(
    parameter int WARMUP_CYCLES   = PIR_WARMUP_CYCLES,
    parameter int DEBOUNCE_CYCLES = PIR_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = PIR_HOLD_CYCLES
) (
    input  logic                     clk_148_mhz,
    input  logic                     rst,
    input  logic                     pir_raw,
    output logic                     sensor_ready,
    output logic                     motion_detected,
    output logic                     motion_start
`ifdef PIR_EVENT_COUNT_EN
    ,
    output logic [EVENT_COUNT_W-1:0] event_count
`endif
);

    localparam int             WW        = cnt_w(WARMUP_CYCLES);
    localparam int             HW        = cnt_w(HOLD_CYCLES);
    localparam logic [WW-1:0]  WARM_LAST = WW'(WARMUP_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic          deb;
    pir_state_t    state_q;
    pir_state_t    state_d;
    logic [WW-1:0] warm_cnt_q;
    logic [WW-1:0] warm_cnt_d;
    logic [HW-1:0] hold_cnt_q;
    logic [HW-1:0] hold_cnt_d;
    logic          ready_q;
    logic          ready_d;
    logic          motion_q;
    logic          motion_d;
    logic          start_q;
    logic          start_d;

    pir_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_148_mhz (clk_148_mhz),
        .rst         (rst),
        .din         (pir_raw),
        .dout        (deb)
    );

    always_ff @(posedge clk_148_mhz) begin
        if (rst) begin
            state_q    <= WARMUP;
            warm_cnt_q <= '0;
            hold_cnt_q <= '0;
            ready_q    <= 1'b0;
            motion_q   <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            ready_q    <= ready_d;
            motion_q   <= motion_d;
            start_q    <= start_d;
        end
    end

    // A returning deb=1 in HOLD is checked before expiry so the episode survives a tie.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = '0;
        hold_cnt_d = '0;
        case (state_q)
            WARMUP: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = IDLE;
                end else begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (deb) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!deb) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (deb) begin
                    state_d = ACTIVE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = WARMUP;
        endcase
    end

    // Outputs are registered copies of the state being entered.
    always_comb begin
        ready_d  = (state_d != WARMUP);
        motion_d = (state_d == ACTIVE) || (state_d == HOLD);
        start_d  = (state_q == IDLE) && (state_d == ACTIVE);
    end

    assign sensor_ready    = ready_q;
    assign motion_detected = motion_q;
    assign motion_start    = start_q;

`ifdef PIR_EVENT_COUNT_EN
    logic [EVENT_COUNT_W-1:0] event_cnt_q;
    logic [EVENT_COUNT_W-1:0] event_cnt_d;

    always_comb begin
        event_cnt_d = event_cnt_q;
        if (start_q && (event_cnt_q != {EVENT_COUNT_W{1'b1}})) begin
            event_cnt_d = event_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_148_mhz) begin
        if (rst) begin
            event_cnt_q <= '0;
        end else begin
            event_cnt_q <= event_cnt_d;
        end
    end

    assign event_count = event_cnt_q;
`endif

endmodule
